// File: rtl/gppcu_pkg.sv
// Shared types and constants for the GPPCU instruction issuer.
// Optional feature macro: GPPCU_ISSUE_CNT_EN (issued-instruction counter).
package gppcu_pkg;

  localparam int INSTR_W = 32;
  // Phase counter width; covers SETUP/HIGH/HOLD lengths up to 256 cycles
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    HOLD  = 2'd3
  } issue_state_t;

endpackage

// File: rtl/gppcu_instr_issuer_if.sv
// Host write port, GPPCU instruction port and status of the issuer.
// Optional feature macro: GPPCU_ISSUE_CNT_EN adds issue_cnt.
interface gppcu_instr_issuer_if #(
  parameter int AW = 4
) ();
  import gppcu_pkg::*;

  logic               wr_valid;
  logic               wr_ready;
  logic [INSTR_W-1:0] wr_data;
  logic               flush;
  logic               stall;
  logic [INSTR_W-1:0] instr;
  logic               instr_clk;
  logic [AW:0]        level;
  logic               idle;
`ifdef GPPCU_ISSUE_CNT_EN
  logic [31:0]        issue_cnt;
`endif

  modport master (
    output wr_valid, wr_data, flush, stall,
    input  wr_ready, instr, instr_clk, level, idle
`ifdef GPPCU_ISSUE_CNT_EN
    , input issue_cnt
`endif
  );

  modport slave (
    input  wr_valid, wr_data, flush, stall,
    output wr_ready, instr, instr_clk, level, idle
`ifdef GPPCU_ISSUE_CNT_EN
    , output issue_cnt
`endif
  );

endinterface

// File: rtl/gppcu_sync_fifo.sv
// Single-clock FIFO with flush; the extra pointer bit separates full from empty.
module gppcu_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [2**AW];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Flush overrides both sides, so a write offered during a flush is dropped
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign level = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/gppcu_instr_issuer.sv
// Drives queued host instructions to the GPPCU with a setup/high/hold strobe.
// Optional feature macro: GPPCU_ISSUE_CNT_EN enables the issued-instruction counter.
module gppcu_instr_issuer
  import gppcu_pkg::*;
#(
  parameter int FIFO_AW   = 4,
  parameter int SETUP_CYC = 1,
  parameter int HIGH_CYC  = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gppcu_instr_issuer_if.slave   bus
);

  issue_state_t       state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               instr_clk_q, instr_clk_next;
  logic [INSTR_W-1:0] instr_q;
  logic [INSTR_W-1:0] fifo_rdata;
  logic               fifo_full, fifo_empty, pop, load;

  gppcu_sync_fifo #(
    .WIDTH (INSTR_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.wr_valid),
    .pop   (pop),
    .flush (bus.flush),
    .wdata (bus.wr_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (bus.level)
  );

  assign bus.wr_ready  = !fifo_full;
  assign bus.instr     = instr_q;
  assign bus.instr_clk = instr_clk_q;
  assign bus.idle      = (state == IDLE) && fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      instr_clk_q <= 1'b0;
      instr_q     <= '0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      instr_clk_q <= instr_clk_next;
      if (load) instr_q <= fifo_rdata;
    end
  end

  // A flush only aborts before the strobe rises; once high the issue runs to completion
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    instr_clk_next = instr_clk_q;
    load           = 1'b0;
    pop            = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !bus.stall && !bus.flush) begin
          pop        = 1'b1;
          load       = 1'b1;
          state_next = SETUP;
          cnt_next   = CNT_W'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (bus.flush) begin
          state_next = IDLE;
        end else if (cnt == '0) begin
          state_next     = HIGH;
          instr_clk_next = 1'b1;
          cnt_next       = CNT_W'(HIGH_CYC - 1);
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      HIGH: begin
        if (cnt == '0) begin
          state_next     = HOLD;
          instr_clk_next = 1'b0;
          cnt_next       = CNT_W'(HOLD_CYC - 1);
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      HOLD: begin
        if (cnt == '0) state_next = IDLE;
        else           cnt_next   = cnt - 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef GPPCU_ISSUE_CNT_EN
  logic [31:0] issue_cnt_q;

  // Counts strobe rising edges; wraps naturally and ignores flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      issue_cnt_q <= '0;
    else if (state == SETUP && state_next == HIGH)
      issue_cnt_q <= issue_cnt_q + 32'd1;
  end

  assign bus.issue_cnt = issue_cnt_q;
`endif

endmodule

// File: tb/tb_gppcu_instr_issuer.sv
// Directed self-checking bench for gppcu_instr_issuer at default parameters.
// Define GPPCU_ISSUE_CNT_EN to also exercise the issue counter.
module tb_gppcu_instr_issuer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  int          cyc = 0;
  logic        prev_clk = 1'b0;
  int          hi_len = 0;
  int          strobe_cyc[$];
  logic [31:0] strobe_val[$];
  int          widths[$];

  gppcu_instr_issuer_if #(.AW(4)) bus ();

  gppcu_instr_issuer #(
    .FIFO_AW   (4),
    .SETUP_CYC (1),
    .HIGH_CYC  (1),
    .HOLD_CYC  (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Strobe monitor: logs rise cycle, instruction value and high width
  always @(posedge clk) begin
    cyc++;
    #2;
    if (bus.instr_clk && !prev_clk) begin
      strobe_cyc.push_back(cyc);
      strobe_val.push_back(bus.instr);
      hi_len = 0;
    end
    if (bus.instr_clk) hi_len++;
    else if (prev_clk) widths.push_back(hi_len);
    prev_clk = bus.instr_clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic f, input logic s);
    bus.wr_valid = v;
    bus.wr_data  = d;
    bus.flush    = f;
    bus.stall    = s;
    tick();
  endtask

  task automatic waitIdle(input int max_cyc);
    int n = 0;
    while (!bus.idle && n < max_cyc) begin
      tick();
      n++;
    end
    if (!bus.idle) checkOutput("idle_timeout", 32'(bus.idle), 32'd1);
  endtask

  task automatic clearLog();
    strobe_cyc.delete();
    strobe_val.delete();
    widths.delete();
  endtask

  task automatic checkStrobes(input string tag, input int n, input logic [31:0] base);
    checkOutput({tag, "_count"}, 32'(strobe_cyc.size()), 32'(n));
    if (strobe_cyc.size() == n) begin
      for (int i = 0; i < n; i++) begin
        checkOutput($sformatf("%s_val%0d", tag, i), strobe_val[i], base + 32'(i));
        if (i > 0)
          checkOutput($sformatf("%s_gap%0d", tag, i), 32'(strobe_cyc[i] - strobe_cyc[i-1]), 32'd4);
      end
    end
  endtask

  initial begin
    logic acc;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.flush    = 1'b0;
    bus.stall    = 1'b0;
    #22 rst_n = 1'b1;
    tick();

    $display("[TB] reset values");
    checkOutput("rst_instr", bus.instr, 32'h0);
    checkOutput("rst_instr_clk", 32'(bus.instr_clk), 32'd0);
    checkOutput("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
    checkOutput("rst_level", 32'(bus.level), 32'd0);
    checkOutput("rst_idle", 32'(bus.idle), 32'd1);
`ifdef GPPCU_ISSUE_CNT_EN
    checkOutput("rst_issue_cnt", bus.issue_cnt, 32'd0);
`endif

    $display("[TB] single issue");
    clearLog();
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    checkOutput("single_e0_level", 32'(bus.level), 32'd1);
    checkOutput("single_e0_idle", 32'(bus.idle), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("single_e1_instr", bus.instr, 32'hDEADBEEF);
    checkOutput("single_e1_clk", 32'(bus.instr_clk), 32'd0);
    checkOutput("single_e1_level", 32'(bus.level), 32'd0);
    tick();
    checkOutput("single_e2_clk", 32'(bus.instr_clk), 32'd1);
    tick();
    checkOutput("single_e3_clk", 32'(bus.instr_clk), 32'd0);
    checkOutput("single_e3_instr", bus.instr, 32'hDEADBEEF);
    checkOutput("single_e3_idle", 32'(bus.idle), 32'd0);
    tick();
    checkOutput("single_e4_idle", 32'(bus.idle), 32'd1);
    checkOutput("single_width", 32'(widths.size() > 0 ? widths[0] : 0), 32'd1);

    $display("[TB] burst of 17");
    clearLog();
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b1);
    checkOutput("burst_full_ready", 32'(bus.wr_ready), 32'd0);
    checkOutput("burst_full_level", 32'(bus.level), 32'd16);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'hA000_0010;
    bus.stall    = 1'b0;
    acc = 1'b0;
    for (int k = 0; k < 20; k++) begin
      acc = bus.wr_ready;
      tick();
      if (acc) break;
    end
    checkOutput("burst_17th_accepted", 32'(acc), 32'd1);
    bus.wr_valid = 1'b0;
    waitIdle(200);
    checkStrobes("burst", 17, 32'hA000_0000);

    $display("[TB] stall");
    clearLog();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'hB000_0000 + 32'(i), 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("stall_level", 32'(bus.level), 32'd3);
    checkOutput("stall_no_strobe", 32'(strobe_cyc.size()), 32'd0);
    bus.stall = 1'b0;
    waitIdle(100);
    checkStrobes("stall", 3, 32'hB000_0000);

    $display("[TB] flush in SETUP");
    clearLog();
    applyStimulus(1'b1, 32'hC000_0001, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hC000_0002, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    bus.flush = 1'b0;
    checkOutput("fsetup_clk", 32'(bus.instr_clk), 32'd0);
    checkOutput("fsetup_level", 32'(bus.level), 32'd0);
    checkOutput("fsetup_idle", 32'(bus.idle), 32'd1);
    for (int i = 0; i < 6; i++) tick();
    checkOutput("fsetup_no_strobe", 32'(strobe_cyc.size()), 32'd0);

    $display("[TB] flush in HIGH with concurrent write");
    clearLog();
    applyStimulus(1'b1, 32'hD000_0001, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hD000_0002, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("fhigh_clk_hi", 32'(bus.instr_clk), 32'd1);
    checkOutput("fhigh_level_before", 32'(bus.level), 32'd1);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'hD000_0003;
    bus.flush    = 1'b1;
    checkOutput("fhigh_ready_during_flush", 32'(bus.wr_ready), 32'd1);
    tick();
    bus.wr_valid = 1'b0;
    bus.flush    = 1'b0;
    checkOutput("fhigh_clk_lo", 32'(bus.instr_clk), 32'd0);
    checkOutput("fhigh_level_after", 32'(bus.level), 32'd0);
    for (int i = 0; i < 6; i++) tick();
    checkOutput("fhigh_idle", 32'(bus.idle), 32'd1);
    checkOutput("fhigh_strobes", 32'(strobe_cyc.size()), 32'd1);
    checkOutput("fhigh_val", strobe_val.size() > 0 ? strobe_val[0] : 32'h0, 32'hD000_0001);
    checkOutput("fhigh_width", 32'(widths.size() > 0 ? widths[0] : 0), 32'd1);

    $display("[TB] reset mid-HIGH");
    applyStimulus(1'b1, 32'hE000_0001, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("rhigh_clk_hi", 32'(bus.instr_clk), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rhigh_clk_async", 32'(bus.instr_clk), 32'd0);
    checkOutput("rhigh_instr", bus.instr, 32'h0);
    checkOutput("rhigh_idle", 32'(bus.idle), 32'd1);
    #1 rst_n = 1'b1;
    tick();
`ifdef GPPCU_ISSUE_CNT_EN
    checkOutput("cnt_after_reset", bus.issue_cnt, 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'hF000_0000 + 32'(i), 1'b0, 1'b0);
    bus.wr_valid = 1'b0;
    waitIdle(100);
    checkOutput("cnt_five", bus.issue_cnt, 32'd5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
